// File: rtl/sample_sync_fifo_pkg.sv
// Shared constants and helpers for the sample FIFO.
// Default geometry and pointer-width calculation.
package sample_sync_fifo_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sample_fifo_ram.sv
// DEPTH x WIDTH register array.
// Synchronous write port, registered read port.
module sample_fifo_ram
    import sample_sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds the last popped word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sample_sync_fifo.sv
// Single-clock sample FIFO with registered output.
// Pointers, count and status flags live here.
module sample_sync_fifo
    import sample_sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = ptr_w(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             write_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_en,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    if (WIDTH < 1) begin : g_bad_width
        $error("sample_sync_fifo: WIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sample_sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_ok;
    logic          rd_ok;

    // Flags and accept decisions derive from the held count.
    always_comb begin
        empty = (count == '0);
        full  = (count == CW'(DEPTH));
        rd_ok = read_en && !empty;
        wr_ok = write_en && (!full || rd_ok);
    end

    // Pointer, count and overflow strobe update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= write_en && full && !read_en;
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            unique case (1'b1)
                wr_ok && !rd_ok: count <= count + 1'b1;
                rd_ok && !wr_ok: count <= count - 1'b1;
                default:         count <= count;
            endcase
        end
    end

    sample_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_ok),
        .waddr   (wptr),
        .wdata   (data_in),
        .re      (rd_ok),
        .raddr   (rptr),
        .rdata   (data_out)
    );

endmodule

// File: tb/tb_sample_sync_fifo.sv
// Bench for sample_sync_fifo.
// Queue-based reference model with directed and random traffic.
module tb_sample_sync_fifo;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         write_en = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         read_en = 1'b0;
    logic [W-1:0] data_out;
    logic         empty;
    logic         full;
    logic [2:0]   count;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] exp_dout = '0;
    logic         exp_ovf = 1'b0;

    sample_sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .write_en (write_en),
        .data_in  (data_in),
        .read_en  (read_en),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"}, data_out, exp_dout);
        check({tag, ".count"}, W'(count), W'(q.size()));
        check({tag, ".empty"}, W'(empty), W'(q.size() == 0));
        check({tag, ".full"}, W'(full), W'(q.size() == D));
        check({tag, ".overflow"}, W'(overflow), W'(exp_ovf));
    endtask

    // One clock with the given inputs, then model update and compare.
    task automatic step(input logic we, input logic [W-1:0] din,
                        input logic re, input string tag);
        int  n;
        bit  popped;
        write_en = we;
        data_in  = din;
        read_en  = re;
        @(posedge clk);
        n = q.size();
        popped = re && n > 0;
        if (popped) exp_dout = q.pop_front();
        if (we && (n < D || popped)) q.push_back(din);
        exp_ovf = we && n == D && !popped;
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        check_all(tag);
    endtask

    initial begin
        #12;
        check_all("reset");
        reset_n = 1'b1;
        @(negedge clk);

        step(1, 32'h1111_1111, 0, "fill0");
        step(1, 32'h2222_2222, 0, "fill1");
        step(1, 32'h3333_3333, 0, "fill2");
        step(1, 32'h4444_4444, 0, "fill3");
        step(1, 32'hDEAD_BEEF, 0, "ovf");
        step(0, 0, 0, "ovf_clear");
        step(1, 32'h0000_0055, 1, "full_wr_rd");
        for (int i = 0; i < 4; i++) step(0, 0, 1, "drain");
        step(0, 0, 1, "drain_empty");
        step(1, 32'h0000_0066, 1, "empty_wr_rd");
        step(0, 0, 1, "read_66");
        for (int i = 0; i < 3; i++) step(0, 0, 1, "underflow");
        step(1, 32'h0000_0077, 0, "post_uf_wr");
        step(0, 0, 1, "post_uf_rd");

        for (int i = 0; i < 10; i++) begin
            step(1, W'(i), 0, "wrap_wr");
            step(1, W'(i) + 32'h100, 1, "wrap_wr_rd");
            step(0, 0, 1, "wrap_rd");
        end

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, $urandom,
                 $urandom_range(0, 99) < 45, "rand");
        end

        while (q.size() > 3) step(0, 0, 1, "trim");
        while (q.size() < 3) step(1, $urandom, 0, "prefill");
        #2;
        reset_n = 1'b0;
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        #1;
        check_all("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0, 1, "rd_after_rst");
        step(0, 0, 1, "rd_after_rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
